parking_controller_param: RTL and testbench

- Clocked, parametrised successor of the campus parking counter. Tracks university and guest occupancy of one car park.
- Guest capacity follows an hour-of-day schedule.
- Per cycle, accepts at most one entry event and one exit event. Each event is tagged as university or guest.
- Sits between the gate sensors/hour source and the display/barrier logic; drives accept/reject pulses and live space counts.

---
 rtl/parking_controller_param.sv | 131 +++++++++++++
 tb/tb_parking_controller_param.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/parking_controller_param.sv
// Car-park occupancy tracker: university/guest counts, hour-scheduled guest limit, registered accept/reject/exit_err pulses.
// Optional reject statistics counter enabled by defining PARKING_REJECT_STATS_EN.
module parking_controller_param #(
    parameter int TOTAL_CAP     = 700,
    parameter int UNI_CAP       = 500,
    parameter int GUEST_CAP_MIN = 200,
    parameter int GUEST_CAP_MAX = 500,
    parameter int RAMP_STEP     = 50,
    parameter int OPEN_HR       = 8,
    parameter int RAMP_HR       = 13,
    parameter int FULL_HR       = 16,
    parameter int CNT_W         = 10,
    parameter int HOUR_W        = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [HOUR_W-1:0] hour,
    input  logic              entry_valid,
    input  logic              entry_is_uni,
    input  logic              exit_valid,
    input  logic              exit_is_uni,
    output logic              entry_accept,
    output logic              entry_reject,
    output logic              exit_err,
    output logic [CNT_W-1:0]  uni_parked,
    output logic [CNT_W-1:0]  guest_parked,
    output logic [CNT_W-1:0]  uni_vacated,
    output logic [CNT_W-1:0]  guest_vacated,
    output logic              uni_has_space,
    output logic              guest_has_space,
`ifdef PARKING_REJECT_STATS_EN
    input  logic              stats_clr,
    output logic [15:0]       reject_cnt,
`endif
    output logic              lot_full
);

    // Two guard bits so sums and differences of counts never wrap.
    localparam int XW = CNT_W + 2;
    typedef logic [XW-1:0] ext_t;

    localparam ext_t TOTAL_X = ext_t'(TOTAL_CAP);
    localparam ext_t UNI_X   = ext_t'(UNI_CAP);

    int   hr;
    int   g_int;
    ext_t guest_lim;

    always_comb begin
        hr    = (int'(hour) >= 24) ? 0 : int'(hour);
        g_int = GUEST_CAP_MAX;
        if (hr >= OPEN_HR && hr < RAMP_HR) begin
            g_int = GUEST_CAP_MIN;
        end else if (hr >= RAMP_HR && hr < FULL_HR) begin
            g_int = GUEST_CAP_MIN + (hr - RAMP_HR + 1) * RAMP_STEP;
            if (g_int > GUEST_CAP_MAX) begin
                g_int = GUEST_CAP_MAX;
            end
        end
    end

    assign guest_lim = ext_t'(g_int);

    // Display-side free-space figures from the registered counts.
    ext_t uni_x, guest_x, free_total, uni_room, guest_room;

    always_comb begin
        uni_x      = ext_t'(uni_parked);
        guest_x    = ext_t'(guest_parked);
        free_total = TOTAL_X - uni_x - guest_x;
        uni_room   = UNI_X - uni_x;
        guest_room = (guest_x >= guest_lim) ? '0 : (guest_lim - guest_x);
    end

    assign uni_vacated     = CNT_W'((uni_room < free_total) ? uni_room : free_total);
    assign guest_vacated   = CNT_W'((guest_room < free_total) ? guest_room : free_total);
    assign uni_has_space   = (uni_vacated != '0);
    assign guest_has_space = (guest_vacated != '0);
    assign lot_full        = ((uni_x + guest_x) == TOTAL_X);

    // The entry decision sees the counts after this cycle's exit.
    logic exit_uni_ok, exit_guest_ok, exit_bad;
    logic grant;
    ext_t uni_a, guest_a, free_a;
    ext_t uni_n, guest_n;

    always_comb begin
        exit_uni_ok   = exit_valid &  exit_is_uni & (uni_parked != '0);
        exit_guest_ok = exit_valid & ~exit_is_uni & (guest_parked != '0);
        exit_bad      = exit_valid & ~(exit_uni_ok | exit_guest_ok);

        uni_a   = uni_x - ext_t'(exit_uni_ok);
        guest_a = guest_x - ext_t'(exit_guest_ok);
        free_a  = TOTAL_X - uni_a - guest_a;

        grant = 1'b0;
        if (entry_valid && free_a != '0) begin
            grant = entry_is_uni ? (uni_a < UNI_X) : (guest_a < guest_lim);
        end

        uni_n   = uni_a + ext_t'(grant & entry_is_uni);
        guest_n = guest_a + ext_t'(grant & ~entry_is_uni);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            uni_parked   <= '0;
            guest_parked <= '0;
            entry_accept <= 1'b0;
            entry_reject <= 1'b0;
            exit_err     <= 1'b0;
        end else begin
            uni_parked   <= CNT_W'(uni_n);
            guest_parked <= CNT_W'(guest_n);
            entry_accept <= grant;
            entry_reject <= entry_valid & ~grant;
            exit_err     <= exit_bad;
        end
    end

`ifdef PARKING_REJECT_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n || stats_clr) begin
            reject_cnt <= '0;
        end else if (entry_valid && !grant && reject_cnt != 16'hFFFF) begin
            reject_cnt <= reject_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_parking_controller_param.sv
// Bench for parking_controller_param: directed scenarios plus random traffic against an occupancy model.
module tb_parking_controller_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] hour = '0;
    logic       entry_valid = 1'b0, entry_is_uni = 1'b0;
    logic       exit_valid = 1'b0, exit_is_uni = 1'b0;
    logic       entry_accept, entry_reject, exit_err;
    logic [9:0] uni_parked, guest_parked, uni_vacated, guest_vacated;
    logic       uni_has_space, guest_has_space, lot_full;
`ifdef PARKING_REJECT_STATS_EN
    logic        stats_clr = 1'b0;
    logic [15:0] reject_cnt;
    int          m_rcnt = 0;
`endif

    parking_controller_param dut (
        .clk(clk), .rst_n(rst_n), .hour(hour),
        .entry_valid(entry_valid), .entry_is_uni(entry_is_uni),
        .exit_valid(exit_valid), .exit_is_uni(exit_is_uni),
        .entry_accept(entry_accept), .entry_reject(entry_reject), .exit_err(exit_err),
        .uni_parked(uni_parked), .guest_parked(guest_parked),
        .uni_vacated(uni_vacated), .guest_vacated(guest_vacated),
        .uni_has_space(uni_has_space), .guest_has_space(guest_has_space),
`ifdef PARKING_REJECT_STATS_EN
        .stats_clr(stats_clr), .reject_cnt(reject_cnt),
`endif
        .lot_full(lot_full)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int m_uni = 0, m_guest = 0, m_acc = 0, m_rej = 0, m_err = 0;
    bit chk_en = 0;

    // Guest limit by hour with the default parameters.
    function automatic int glim(input int h);
        case (h)
            8, 9, 10, 11, 12: return 200;
            13: return 250;
            14: return 300;
            15: return 350;
            default: return 500;
        endcase
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Occupancy model advanced once per clock edge from the inputs presented.
    task automatic step();
        int u, g, acc, rej, err;
        u = m_uni; g = m_guest; acc = 0; rej = 0; err = 0;
        if (!rst_n) begin
            u = 0; g = 0;
        end else begin
            if (exit_valid) begin
                if (exit_is_uni) begin
                    if (u > 0) u--; else err = 1;
                end else begin
                    if (g > 0) g--; else err = 1;
                end
            end
            if (entry_valid) begin
                if (u + g < 700 && (entry_is_uni ? (u < 500) : (g < glim(int'(hour))))) begin
                    acc = 1;
                    if (entry_is_uni) u++; else g++;
                end else begin
                    rej = 1;
                end
            end
        end
`ifdef PARKING_REJECT_STATS_EN
        if (!rst_n || stats_clr) m_rcnt = 0;
        else if (rej == 1 && m_rcnt < 65535) m_rcnt++;
`endif
        @(posedge clk);
        m_uni = u; m_guest = g; m_acc = acc; m_rej = rej; m_err = err;
        #1;
    endtask

    task automatic cyc(input bit ev, input bit eu, input bit xv, input bit xu);
        entry_valid = ev; entry_is_uni = eu; exit_valid = xv; exit_is_uni = xu;
        step();
        entry_valid = 0; exit_valid = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        step();
        rst_n = 1;
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            int free_t, gl;
            free_t = 700 - m_uni - m_guest;
            gl = glim((int'(hour) >= 24) ? 0 : int'(hour));
            chk("uni_parked", int'(uni_parked), m_uni);
            chk("guest_parked", int'(guest_parked), m_guest);
            chk("entry_accept", int'(entry_accept), m_acc);
            chk("entry_reject", int'(entry_reject), m_rej);
            chk("exit_err", int'(exit_err), m_err);
            chk("uni_vacated", int'(uni_vacated), imin(500 - m_uni, free_t));
            chk("guest_vacated", int'(guest_vacated), (m_guest >= gl) ? 0 : imin(gl - m_guest, free_t));
            chk("uni_has_space", int'(uni_has_space), int'(imin(500 - m_uni, free_t) != 0));
            chk("lot_full", int'(lot_full), int'(free_t == 0));
            chk("guest_has_space", int'(guest_has_space), int'(m_guest < gl && free_t != 0));
`ifdef PARKING_REJECT_STATS_EN
            chk("reject_cnt", int'(reject_cnt), m_rcnt);
`endif
        end
    end

    initial begin
        do_reset();
        chk_en = 1;
        chk("reset_uni", int'(uni_parked), 0);
        chk("reset_accept", int'(entry_accept), 0);

        // University fill to its cap at hour 0.
        hour = 0;
        repeat (500) cyc(1, 1, 0, 0);
        chk("uni_500", int'(uni_parked), 500);
        chk("uni_no_space", int'(uni_has_space), 0);
        cyc(1, 1, 0, 0);
        chk("uni_501_reject", int'(entry_reject), 1);

        // Guest limit during restricted hours, then widened by the ramp.
        do_reset();
        hour = 9;
        repeat (201) cyc(1, 0, 0, 0);
        chk("guest_201_reject", int'(entry_reject), 1);
        chk("guest_200", int'(guest_parked), 200);
        chk("guest_vac_h9", int'(guest_vacated), 0);
        hour = 14;
        #1;
        chk("guest_vac_h14", int'(guest_vacated), 100);

        // Full lot: exit+entry in the same cycle.
        hour = 9;
        repeat (500) cyc(1, 1, 0, 0);
        chk("lot_full_set", int'(lot_full), 1);
        cyc(1, 1, 1, 0);
        chk("full_uni_reject", int'(entry_reject), 1);
        chk("full_guest_199", int'(guest_parked), 199);
        cyc(1, 0, 0, 0);
        chk("refill_full", int'(lot_full), 1);
        cyc(1, 0, 1, 0);
        chk("swap_guest_accept", int'(entry_accept), 1);
        chk("swap_guest_cnt", int'(guest_parked), 200);

        // Guest limit dropping below occupancy.
        do_reset();
        hour = 20;
        repeat (450) cyc(1, 0, 0, 0);
        hour = 10;
        #1;
        chk("shrink_vac0", int'(guest_vacated), 0);
        cyc(1, 0, 0, 0);
        chk("shrink_reject", int'(entry_reject), 1);
        chk("shrink_keep450", int'(guest_parked), 450);
        repeat (251) cyc(0, 0, 1, 0);
        chk("drain_199", int'(guest_parked), 199);
        cyc(1, 0, 0, 0);
        chk("drain_accept", int'(entry_accept), 1);

        // Exit from an empty class.
        do_reset();
        cyc(0, 0, 1, 1);
        chk("exit_err_pulse", int'(exit_err), 1);
        chk("exit_err_uni0", int'(uni_parked), 0);
        cyc(0, 0, 0, 0);
        chk("exit_err_clear", int'(exit_err), 0);

        // Reset with a request pending, then an out-of-range hour.
        repeat (5) cyc(1, 1, 0, 0);
        entry_valid = 1; entry_is_uni = 1;
        do_reset();
        entry_valid = 0;
        chk("rst_mid_uni", int'(uni_parked), 0);
        chk("rst_mid_acc", int'(entry_accept), 0);
        chk("rst_mid_rej", int'(entry_reject), 0);
        hour = 25;
        #1;
        chk("hour25_guest_vac", int'(guest_vacated), 500);

        // Random traffic, biased towards entries so the lot saturates.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) hour = 5'($urandom_range(0, 31));
            rst_n = ($urandom_range(0, 299) != 0);
            cyc($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                $urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1);
            rst_n = 1;
        end

        chk_en = 0;
        #10;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
